// File: rtl/hwpe_stream_package.sv
// Shared HWPE-Stream helpers: low-aligned strobe masks and a prefix-shape check.
package hwpe_stream_package;

  localparam int unsigned StrbMaxNb = 64;

  // Returns a mask with the lowest min(count, nb) bits set.
  function automatic logic [StrbMaxNb-1:0] hwpe_stream_prefix_strb(input int unsigned count,
                                                                   input int unsigned nb);
    logic [StrbMaxNb-1:0] mask;
    for (int unsigned i = 0; i < StrbMaxNb; i++) begin
      mask[i] = (i < count) && (i < nb);
    end
    return mask;
  endfunction

  // A strobe is a prefix when its ones form one run starting at bit 0.
  function automatic logic hwpe_stream_strb_is_prefix(input logic [StrbMaxNb-1:0] strb);
    return ((strb + StrbMaxNb'(1)) & strb) == '0;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE-Stream handshake bundle: valid/ready with byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_strb_popcount.sv
// Counts set bits of a byte-strobe vector.
module hwpe_stream_strb_popcount #(
  parameter  int unsigned NB = 4,
  localparam int unsigned CW = $clog2(NB + 1)
) (
  input  logic [NB-1:0] strb_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NB; i++) begin
      count_o = count_o + CW'(strb_i[i]);
    end
  end

endmodule

// File: rtl/hwpe_stream_strb_packer.sv
// Repacks prefix-strobed beats into dense full words; flush emits the residual
// bytes as one partial word with a prefix strobe.
module hwpe_stream_strb_packer
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   clear_i,
  input  logic                   flush_i,
  output logic                   idle_o,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned FW = $clog2(NB);
  localparam int unsigned CW = $clog2(NB + 1);
  localparam int unsigned SW = FW + 2;

  typedef enum logic {StPack, StFlush} state_e;

  state_e                  r_state, w_state_next;
  logic [FW-1:0]           r_fill, w_fill_next;
  logic [DATA_WIDTH-1:0]   r_acc, w_acc_next;
  logic                    r_out_valid, w_out_valid_next;
  logic [DATA_WIDTH-1:0]   r_out_data, w_out_data_next;
  logic [NB-1:0]           r_out_strb, w_out_strb_next;

  logic [CW-1:0]           w_k;
  logic [NB-1:0]           w_k_mask, w_fill_mask;
  logic [DATA_WIDTH-1:0]   w_byte_mask;
  logic [2*DATA_WIDTH-1:0] w_comb;
  logic [SW-1:0]           w_sum;
  logic                    w_out_free, w_push_ready, w_push_fire;
  logic                    w_unused_test_mode;

  assign w_unused_test_mode = test_mode_i;

  hwpe_stream_strb_popcount #(
    .NB (NB)
  ) i_popcount (
    .strb_i  (push_i.strb),
    .count_o (w_k)
  );

  // Only the lowest k bytes are trusted, even if the strobe is malformed.
  always_comb begin
    w_k_mask    = NB'(hwpe_stream_prefix_strb(32'(w_k), NB));
    w_fill_mask = NB'(hwpe_stream_prefix_strb(32'(r_fill), NB));
    for (int i = 0; i < NB; i++) begin
      w_byte_mask[8*i +: 8] = {8{w_k_mask[i]}};
    end
  end

  assign w_comb = {{DATA_WIDTH{1'b0}}, r_acc}
                | ({{DATA_WIDTH{1'b0}}, push_i.data & w_byte_mask} << {r_fill, 3'b000});
  assign w_sum  = SW'(r_fill) + SW'(w_k);

  assign w_out_free   = ~r_out_valid | pop_o.ready;
  assign w_push_ready = w_out_free & (r_state == StPack);
  assign w_push_fire  = push_i.valid & w_push_ready;

  always_comb begin
    w_state_next     = r_state;
    w_fill_next      = r_fill;
    w_acc_next       = r_acc;
    w_out_valid_next = r_out_valid & ~pop_o.ready;
    w_out_data_next  = r_out_data;
    w_out_strb_next  = r_out_strb;
    if (clear_i) begin
      w_state_next     = StPack;
      w_fill_next      = '0;
      w_acc_next       = '0;
      w_out_valid_next = 1'b0;
      w_out_data_next  = '0;
      w_out_strb_next  = '0;
    end else begin
      case (r_state)
        StPack: begin
          if (w_push_fire && (w_k != '0)) begin
            if (w_sum >= SW'(NB)) begin
              w_out_data_next  = w_comb[DATA_WIDTH-1:0];
              w_out_strb_next  = '1;
              w_out_valid_next = 1'b1;
              w_acc_next       = w_comb[2*DATA_WIDTH-1:DATA_WIDTH];
              w_fill_next      = FW'(w_sum - SW'(NB));
            end else begin
              w_acc_next  = w_comb[DATA_WIDTH-1:0];
              w_fill_next = FW'(w_sum);
            end
          end
          // Flush looks at the fill after this cycle's push has been absorbed.
          if (flush_i && (w_fill_next != '0)) begin
            w_state_next = StFlush;
          end
        end
        StFlush: begin
          if (w_out_free) begin
            w_out_data_next  = r_acc;
            w_out_strb_next  = w_fill_mask;
            w_out_valid_next = 1'b1;
            w_fill_next      = '0;
            w_acc_next       = '0;
            w_state_next     = StPack;
          end
        end
        default: w_state_next = StPack;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StPack;
      r_fill      <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_fill      <= w_fill_next;
      r_acc       <= w_acc_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_strb  <= w_out_strb_next;
    end
  end

  assign push_i.ready = w_push_ready;
  assign pop_o.valid  = r_out_valid;
  assign pop_o.data   = r_out_data;
  assign pop_o.strb   = r_out_strb;
  assign idle_o       = (r_state == StPack) & (r_fill == '0) & ~r_out_valid;

  a_prefix_strb : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i.valid |-> hwpe_stream_strb_is_prefix(64'(push_i.strb)));

endmodule

// File: tb/tb_hwpe_stream_strb_packer.sv
// Directed bench for the strobe packer with NB=4.
module tb_hwpe_stream_strb_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode = 1'b0;
  logic clear = 1'b0;
  logic flush = 1'b0;
  logic idle;
  int   n_checks = 0;
  int   n_errors = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_if ();

  hwpe_stream_strb_packer #(
    .DATA_WIDTH (32)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .clear_i     (clear),
    .flush_i     (flush),
    .idle_o      (idle),
    .push_i      (push_if),
    .pop_o       (pop_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Enters and leaves one time unit after a rising edge.
  task automatic push_beat(input logic [31:0] data, input logic [3:0] strb, input logic fl);
    push_if.valid = 1'b1;
    push_if.data  = data;
    push_if.strb  = strb;
    flush         = fl;
    #1;
    chk("push_ready", push_if.ready, 1);
    @(posedge clk);
    #1;
    push_if.valid = 1'b0;
    push_if.strb  = '0;
    flush         = 1'b0;
  endtask

  initial begin
    push_if.valid = 1'b0;
    push_if.data  = '0;
    push_if.strb  = '0;
    pop_if.ready  = 1'b1;
    #1;
    chk("rst_valid", pop_if.valid, 0);
    chk("rst_data", pop_if.data, 0);
    chk("rst_strb", pop_if.strb, 0);
    chk("rst_idle", idle, 1);
    chk("rst_fill", dut.r_fill, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Full beats pass straight through with one cycle of latency.
    push_beat(32'h03020100, 4'hF, 1'b0);
    chk("full0_valid", pop_if.valid, 1);
    chk("full0_data", pop_if.data, 32'h03020100);
    chk("full0_strb", pop_if.strb, 4'hF);
    push_beat(32'h13121110, 4'hF, 1'b0);
    chk("full1_data", pop_if.data, 32'h13121110);
    push_beat(32'h23222120, 4'hF, 1'b0);
    chk("full2_data", pop_if.data, 32'h23222120);
    chk("full2_strb", pop_if.strb, 4'hF);
    cycle();
    chk("full_end_valid", pop_if.valid, 0);
    chk("full_end_idle", idle, 1);

    // Two 3-byte beats pack into one word; flush emits the 2-byte tail.
    push_beat(32'hEEA2A1A0, 4'h7, 1'b0);
    chk("pk_a_valid", pop_if.valid, 0);
    chk("pk_a_fill", dut.r_fill, 3);
    chk("pk_a_idle", idle, 0);
    push_beat(32'hDDB2B1B0, 4'h7, 1'b0);
    chk("pk_b_valid", pop_if.valid, 1);
    chk("pk_b_data", pop_if.data, 32'hB0A2A1A0);
    chk("pk_b_strb", pop_if.strb, 4'hF);
    chk("pk_b_fill", dut.r_fill, 2);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fl_wait_valid", pop_if.valid, 0);
    chk("fl_wait_ready", push_if.ready, 0);
    chk("fl_wait_idle", idle, 0);
    cycle();
    chk("fl_valid", pop_if.valid, 1);
    chk("fl_data", pop_if.data, 32'h0000B2B1);
    chk("fl_strb", pop_if.strb, 4'h3);
    chk("fl_fill", dut.r_fill, 0);
    cycle();
    chk("fl_end_valid", pop_if.valid, 0);
    chk("fl_end_idle", idle, 1);

    // Backpressure holds the output word and stalls the push side.
    pop_if.ready = 1'b0;
    push_beat(32'hCAFEF00D, 4'hF, 1'b0);
    chk("bp_valid", pop_if.valid, 1);
    chk("bp_data", pop_if.data, 32'hCAFEF00D);
    push_if.valid = 1'b1;
    push_if.data  = 32'h5A5AA5A5;
    push_if.strb  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_push_ready", push_if.ready, 0);
      chk("bp_hold_valid", pop_if.valid, 1);
      chk("bp_hold_data", pop_if.data, 32'hCAFEF00D);
      chk("bp_hold_strb", pop_if.strb, 4'hF);
      @(posedge clk);
      #1;
    end
    pop_if.ready = 1'b1;
    #1;
    chk("bp_release_ready", push_if.ready, 1);
    @(posedge clk);
    #1;
    push_if.valid = 1'b0;
    push_if.strb  = '0;
    chk("bp_next_valid", pop_if.valid, 1);
    chk("bp_next_data", pop_if.data, 32'h5A5AA5A5);
    cycle();
    chk("bp_end_valid", pop_if.valid, 0);

    // Flush with nothing buffered is a no-op.
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("nofl_valid", pop_if.valid, 0);
    chk("nofl_idle", idle, 1);
    chk("nofl_ready", push_if.ready, 1);
    cycle();
    chk("nofl_valid2", pop_if.valid, 0);

    // Push completing the word together with flush leaves nothing to flush.
    push_beat(32'h00C2C1C0, 4'h7, 1'b0);
    chk("pf_fill3", dut.r_fill, 3);
    chk("pf_valid0", pop_if.valid, 0);
    push_beat(32'hFFFFFFD0, 4'h1, 1'b1);
    chk("pf_valid", pop_if.valid, 1);
    chk("pf_data", pop_if.data, 32'hD0C2C1C0);
    chk("pf_strb", pop_if.strb, 4'hF);
    chk("pf_fill", dut.r_fill, 0);
    chk("pf_ready", push_if.ready, 1);
    cycle();
    chk("pf_end_valid", pop_if.valid, 0);
    chk("pf_end_idle", idle, 1);
    cycle();
    chk("pf_no_flush_word", pop_if.valid, 0);

    // Clear drops both the pending word and the residual bytes.
    push_beat(32'h00F2F1F0, 4'h7, 1'b0);
    push_beat(32'h00F5F4F3, 4'h7, 1'b0);
    chk("clr_pre_valid", pop_if.valid, 1);
    chk("clr_pre_data", pop_if.data, 32'hF3F2F1F0);
    chk("clr_pre_fill", dut.r_fill, 2);
    pop_if.ready = 1'b0;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    pop_if.ready = 1'b1;
    chk("clr_valid", pop_if.valid, 0);
    chk("clr_data", pop_if.data, 0);
    chk("clr_strb", pop_if.strb, 0);
    chk("clr_fill", dut.r_fill, 0);
    chk("clr_idle", idle, 1);
    chk("clr_ready", push_if.ready, 1);
    push_beat(32'h11223344, 4'hF, 1'b0);
    chk("clr_after_valid", pop_if.valid, 1);
    chk("clr_after_data", pop_if.data, 32'h11223344);
    chk("clr_after_strb", pop_if.strb, 4'hF);
    cycle();
    chk("clr_after_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
